// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
// Tracks register usage of the EX, MEM and WB stages in shadow registers and
// produces stall, bubble, flush, freeze and EX operand forwarding selects.
// All control outputs are combinational from the current state and inputs.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              ex_branch_taken,
  input  logic              mem_dmem_req,
  input  logic              dmem_ready,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic              freeze_all,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              load;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } shadow_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state_q;
  state_t            next_state;
  shadow_t           stage_q [3];
  shadow_t           id_entry;
  logic              armed_q;
  logic              mem_wait;
  logic              load_use;
  logic              inc_stall;
  logic              inc_flush;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  // A stage can hazard only if it really writes a register other than the hard zero
  function automatic logic is_target(input shadow_t s);
    return s.valid && s.wr && (s.rd != ZERO_IDX);
  endfunction

  // The younger MEM result wins over WB when both write the same register
  function automatic logic [1:0] fwd_sel(input shadow_t m, input shadow_t w,
                                         input logic [REG_AW-1:0] rs, input logic use_rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs) begin
      if (is_target(m) && (m.rd == rs)) begin
        sel = 2'b01;
      end else if (is_target(w) && (w.rd == rs)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  // Pack the ID instruction into shadow form; an invalid slot carries no usage at all
  always_comb begin
    id_entry = '0;
    if (id_valid) begin
      id_entry.valid   = 1'b1;
      id_entry.rd      = id_rd;
      id_entry.wr      = id_wr;
      id_entry.load    = id_load;
      id_entry.rs1     = id_rs1;
      id_entry.rs2     = id_rs2;
      id_entry.use_rs1 = id_use_rs1;
      id_entry.use_rs2 = id_use_rs2;
    end
  end

  // Raw hazard conditions before priority is applied
  always_comb begin
    mem_wait = mem_dmem_req && !dmem_ready;
    load_use = is_target(stage_q[EX]) && stage_q[EX].load && id_valid &&
               ((id_use_rs1 && (id_rs1 == stage_q[EX].rd)) ||
                (id_use_rs2 && (id_rs2 == stage_q[EX].rd)));
  end

  // Next-state and control outputs: memory wait beats branch, branch beats load-use
  always_comb begin
    next_state   = state_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    freeze_all   = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    inc_stall    = 1'b0;
    inc_flush    = 1'b0;
    if (!armed_q) begin
      next_state = RUN;
    end else if (mem_wait) begin
      freeze_all = 1'b1;
      inc_stall  = 1'b1;
      next_state = MEM_WAIT;
    end else begin
      fwd_a      = fwd_sel(stage_q[MEM], stage_q[WB], stage_q[EX].rs1, stage_q[EX].use_rs1);
      fwd_b      = fwd_sel(stage_q[MEM], stage_q[WB], stage_q[EX].rs2, stage_q[EX].use_rs2);
      next_state = RUN;
      case (state_q)
        LU_STALL: begin
          next_state = RUN;
        end
        default: begin
          if (ex_branch_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            inc_flush    = 1'b1;
          end else if (load_use) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            inc_stall    = 1'b1;
            next_state   = LU_STALL;
          end
        end
      endcase
    end
  end

  // State register plus a flag that keeps outputs quiet in the first cycle out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      armed_q <= 1'b0;
    end else begin
      state_q <= next_state;
      armed_q <= 1'b1;
    end
  end

  // Shadow pipeline advances in step with the real one and holds while frozen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q[EX]  <= '0;
      stage_q[MEM] <= '0;
      stage_q[WB]  <= '0;
    end else if (!freeze_all) begin
      stage_q[WB]  <= stage_q[MEM];
      stage_q[MEM] <= stage_q[EX];
      stage_q[EX]  <= bubble_id_ex ? '0 : id_entry;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (inc_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (inc_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table of per-cycle vectors,
// hand-written multi-cycle sequences, expected values queued as a scoreboard.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0;
  logic [AW-1:0] id_rs2 = '0;
  logic          id_use_rs1 = 1'b0;
  logic          id_use_rs2 = 1'b0;
  logic [AW-1:0] id_rd = '0;
  logic          id_wr = 1'b0;
  logic          id_load = 1'b0;
  logic          ex_branch_taken = 1'b0;
  logic          mem_dmem_req = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          stall_pc;
  logic          stall_if_id;
  logic          bubble_id_ex;
  logic          flush_if_id;
  logic          freeze_all;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;
  int row_idx = 0;

  typedef struct {
    logic          rst;
    logic          vld;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          wr;
    logic          ld;
    logic          br;
    logic          req;
    logic          rdy;
    logic [4:0]    ctrl;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  pipeline_hazard_ctrl #(.REG_AW(AW), .ZERO_REG(31), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
    .ex_branch_taken(ex_branch_taken), .mem_dmem_req(mem_dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .freeze_all(freeze_all),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int rst, input int vld, input int rs1, input int rs2,
                              input int u1, input int u2, input int rd, input int wr,
                              input int ld, input int br, input int req, input int rdy,
                              input int ctrl, input int fa, input int fb,
                              input int sc, input int fc);
    vec_t v;
    v.rst = rst[0]; v.vld = vld[0]; v.rs1 = rs1[AW-1:0]; v.rs2 = rs2[AW-1:0];
    v.u1 = u1[0]; v.u2 = u2[0]; v.rd = rd[AW-1:0]; v.wr = wr[0]; v.ld = ld[0];
    v.br = br[0]; v.req = req[0]; v.rdy = rdy[0];
    v.ctrl = ctrl[4:0]; v.fa = fa[1:0]; v.fb = fb[1:0];
    v.sc = sc[CW-1:0]; v.fc = fc[CW-1:0];
    return v;
  endfunction

  function automatic vec_t nop(input int ctrl, input int fa, input int fb, input int sc, input int fc);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctrl, fa, fb, sc, fc);
  endfunction

  function automatic vec_t frz(input int ctrl, input int sc, input int fc, input int br, input int rdy);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, br, 1, rdy, ctrl, 0, 0, sc, fc);
  endfunction

  task automatic compare(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %0h, expected %0h", name, row_idx, act, req);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard row %0d: got empty queue, expected an entry", row_idx);
    end else begin
      e = exp_q.pop_front();
      compare("ctrl", int'({stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze_all}), int'(e.ctrl));
      compare("fwd_a", int'(fwd_a), int'(e.fa));
      compare("fwd_b", int'(fwd_b), int'(e.fb));
      compare("stall_cnt", int'(stall_cnt), int'(e.sc));
      compare("flush_cnt", int'(flush_cnt), int'(e.fc));
    end
    row_idx++;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset           = v.rst;
    id_valid        = v.vld;
    id_rs1          = v.rs1;
    id_rs2          = v.rs2;
    id_use_rs1      = v.u1;
    id_use_rs2      = v.u2;
    id_rd           = v.rd;
    id_wr           = v.wr;
    id_load         = v.ld;
    ex_branch_taken = v.br;
    mem_dmem_req    = v.req;
    dmem_ready      = v.rdy;
    exp_q.push_back(v);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    // Reset held, then the quiet first cycle with hostile inputs
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    // ADD X5,X31,X31 ; LSL X10,X5,#3 -> MEM forward on operand a
    tbl.push_back(mk(1, 1, 31, 31, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 1, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0));
    // ADDI X6 ; NOP ; ADD X7,X6,X6 -> WB forward on both operands
    tbl.push_back(mk(1, 1, 31, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 6, 6, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 2, 2, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0));
    // LDUR X12 ; ADD X14,X12,X1 -> one stall cycle then WB forward
    tbl.push_back(mk(1, 1, 11, 0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 12, 1, 1, 1, 14, 1, 0, 0, 0, 0, 5'b11100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 12, 1, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(nop(0, 2, 0, 1, 0));
    tbl.push_back(nop(0, 0, 0, 1, 0));
    tbl.push_back(nop(0, 0, 0, 1, 0));
    // LDUR X31 then reader of X31 -> no stall, no forward
    tbl.push_back(mk(1, 1, 11, 0, 1, 0, 31, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 31, 31, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(nop(0, 0, 0, 1, 0));
    tbl.push_back(nop(0, 0, 0, 1, 0));
    tbl.push_back(nop(0, 0, 0, 1, 0));
    // Taken branch with a load-use pending in ID -> flush wins
    tbl.push_back(mk(1, 1, 11, 0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 12, 1, 1, 1, 14, 1, 0, 1, 0, 0, 5'b00110, 0, 0, 1, 0));
    tbl.push_back(nop(0, 0, 0, 1, 1));
    tbl.push_back(nop(0, 0, 0, 1, 1));
    tbl.push_back(nop(0, 0, 0, 1, 1));
    // Two writers of X5 in a row -> MEM beats WB on operand b
    tbl.push_back(mk(1, 1, 31, 31, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 5, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(nop(0, 0, 1, 1, 1));
    tbl.push_back(nop(0, 0, 0, 1, 1));
    tbl.push_back(nop(0, 0, 0, 1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
    end

    // STUR waiting 3 cycles on memory, taken branch held in EX until release
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(frz(5'b00001, i, 0, 1, 0));
    end
    applyStimulus(frz(5'b00110, 3, 0, 1, 1));
    applyStimulus(nop(0, 0, 0, 3, 1));

    // Reset asserted in the middle of a memory wait
    applyStimulus(frz(5'b00001, 3, 1, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(0, 0, 0, 0, 0));

    // Reset asserted during the load-use stall cycle clears the shadows
    applyStimulus(mk(1, 1, 11, 0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 1, 12, 1, 1, 1, 14, 1, 0, 0, 0, 0, 5'b11100, 0, 0, 0, 0));
    applyStimulus(mk(0, 1, 12, 1, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 1, 12, 1, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(0, 0, 0, 0, 0));

    // Long memory wait drives stall_cnt into saturation
    for (int i = 0; i < 18; i++) begin
      applyStimulus(frz(5'b00001, (i > 15) ? 15 : i, 0, 0, 0));
    end
    applyStimulus(nop(0, 0, 0, 15, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
